// File: rtl/ibex_bus_guard.sv
// rtl/ibex_bus_guard.sv - per-channel bus protocol guard for the Ibex instr/data ports
//
// Sits between the core's request/response ports and the interconnect. For each channel it
// tracks accepted-but-unanswered requests, throttles at MaxOutstanding, flags responses that
// arrive with nothing outstanding, times out silent responders, and generates/checks the 7-bit
// SECDED(39,32) bus integrity. Findings are kept as sticky per-channel status and summarised
// on two alert outputs.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   host_req_i             core request per channel
//   host_gnt_o             grant back to the core (dev grant qualified by the gated request)
//   host_rvalid_o          response valid to the core, spurious beats removed
//   host_err_o             response error to the core (device error or integrity mismatch)
//   host_wdata_i           core write data, 32 bits per channel
//   dev_req_o              gated request to the interconnect
//   dev_gnt_i              interconnect grant
//   dev_rvalid_i           interconnect response valid
//   dev_err_i              interconnect response error
//   dev_rdata_i            response data, 32 bits per channel
//   dev_rdata_intg_i       response check bits, 7 bits per channel
//   dev_wdata_intg_o       generated write check bits, 7 bits per channel
//   clr_i                  clear sticky status and timeout lock of a channel
//   outstanding_o          outstanding request count, CntW bits per channel
//   err_status_o           sticky {intg, timeout, spurious}, 3 bits per channel
//   alert_minor_o          one-cycle pulse on a clean device-error response
//   alert_major_o          level, set while any sticky status bit is set

module ibex_bus_guard #(
  parameter int unsigned NumChannels    = 2,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned TimeoutCycles  = 1024,
  parameter bit          IntgEnable     = 1'b1,
  parameter int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumChannels-1:0]      host_req_i,
  output logic [NumChannels-1:0]      host_gnt_o,
  output logic [NumChannels-1:0]      host_rvalid_o,
  output logic [NumChannels-1:0]      host_err_o,
  input  logic [NumChannels*32-1:0]   host_wdata_i,
  output logic [NumChannels-1:0]      dev_req_o,
  input  logic [NumChannels-1:0]      dev_gnt_i,
  input  logic [NumChannels-1:0]      dev_rvalid_i,
  input  logic [NumChannels-1:0]      dev_err_i,
  input  logic [NumChannels*32-1:0]   dev_rdata_i,
  input  logic [NumChannels*7-1:0]    dev_rdata_intg_i,
  output logic [NumChannels*7-1:0]    dev_wdata_intg_o,
  input  logic [NumChannels-1:0]      clr_i,
  output logic [NumChannels*CntW-1:0] outstanding_o,
  output logic [NumChannels*3-1:0]    err_status_o,
  output logic                        alert_minor_o,
  output logic                        alert_major_o
);

  localparam int unsigned TmrW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TimeoutCycles - 1);
  localparam logic [TmrW-1:0] TmrPre  = TmrW'(TimeoutCycles - 2);

  // SECDED(39,32) encoder check bits: each bit is the parity of the data under one mask.
  function automatic logic [6:0] secded_enc(input logic [31:0] d);
    logic [6:0] c;
    c[0] = ^(d & 32'h2606BD25);
    c[1] = ^(d & 32'hDEBA8050);
    c[2] = ^(d & 32'h413D89AA);
    c[3] = ^(d & 32'h31234ED1);
    c[4] = ^(d & 32'hC2C1323B);
    c[5] = ^(d & 32'h2DCC624C);
    c[6] = ^(d & 32'h98505586);
    return c;
  endfunction

  logic [NumChannels-1:0]   w_minor_evt;
  logic [NumChannels*3-1:0] w_status_flat;
  logic                     r_alert_minor;
  logic                     r_alert_major;

  for (genvar g = 0; g < NumChannels; g++) begin : g_ch
    logic [CntW-1:0] r_count;
    logic [TmrW-1:0] r_timer;
    logic [2:0]      r_status;
    logic            r_lock;

    logic            w_full;
    logic            w_nonzero;
    logic            w_dev_req;
    logic            w_accept;
    logic            w_rsp;
    logic            w_spurious;
    logic            w_intg_bad;
    logic            w_timeout;
    logic [6:0]      w_intg_calc;

    always_comb begin
      w_full      = (r_count == MaxCnt);
      w_nonzero   = (r_count != '0);
      w_dev_req   = host_req_i[g] & ~w_full & ~r_lock;
      w_accept    = dev_gnt_i[g] & w_dev_req;
      w_rsp       = dev_rvalid_i[g] & w_nonzero;
      w_spurious  = dev_rvalid_i[g] & ~w_nonzero;
      w_intg_calc = secded_enc(dev_rdata_i[g*32 +: 32]);
      w_intg_bad  = IntgEnable && w_rsp && (w_intg_calc != dev_rdata_intg_i[g*7 +: 7]);
      // Fires on the edge where the timer steps onto its last value; it then holds there,
      // so a channel reports a given stall only once.
      w_timeout   = w_nonzero & ~w_rsp & (r_timer == TmrPre);
    end

    assign dev_req_o[g]             = w_dev_req;
    assign host_gnt_o[g]            = w_accept;
    assign host_rvalid_o[g]         = w_rsp;
    assign host_err_o[g]            = w_rsp & (dev_err_i[g] | w_intg_bad);
    assign dev_wdata_intg_o[g*7 +: 7] = IntgEnable ? secded_enc(host_wdata_i[g*32 +: 32]) : 7'd0;
    assign outstanding_o[g*CntW +: CntW] = r_count;
    assign w_status_flat[g*3 +: 3]  = r_status;
    // A device error only counts as a minor alert when the beat itself is trustworthy.
    assign w_minor_evt[g]           = w_rsp & dev_err_i[g] & ~w_intg_bad;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_count  <= '0;
        r_timer  <= '0;
        r_status <= 3'b000;
        r_lock   <= 1'b0;
      end else begin
        // Accept is gated by full and decrement by nonzero, so the counter cannot over/underflow.
        case ({w_accept, w_rsp})
          2'b10:   r_count <= r_count + CntW'(1);
          2'b01:   r_count <= r_count - CntW'(1);
          default: r_count <= r_count;
        endcase

        if (!w_nonzero || w_rsp) begin
          r_timer <= '0;
        end else if (r_timer != TmrLast) begin
          r_timer <= r_timer + TmrW'(1);
        end

        // Clear first, then OR in this cycle's events so a coincident event survives clr.
        r_status <= (clr_i[g] ? 3'b000 : r_status) | {w_intg_bad, w_timeout, w_spurious};
        r_lock   <= (clr_i[g] ? 1'b0 : r_lock) | w_timeout;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_alert_minor <= 1'b0;
      r_alert_major <= 1'b0;
    end else begin
      r_alert_minor <= |w_minor_evt;
      r_alert_major <= |w_status_flat;
    end
  end

  assign err_status_o  = w_status_flat;
  assign alert_minor_o = r_alert_minor;
  assign alert_major_o = r_alert_major;

endmodule

// File: tb/tb_ibex_bus_guard.sv
// tb/tb_ibex_bus_guard.sv - directed self-checking bench for ibex_bus_guard

module tb_ibex_bus_guard;

  localparam int NC = 2;
  localparam int MO = 2;
  localparam int TC = 16;
  localparam int CW = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [NC-1:0] host_req_i, host_gnt_o, host_rvalid_o, host_err_o;
  logic [NC*32-1:0] host_wdata_i;
  logic [NC-1:0] dev_req_o, dev_gnt_i, dev_rvalid_i, dev_err_i;
  logic [NC*32-1:0] dev_rdata_i;
  logic [NC*7-1:0]  dev_rdata_intg_i, dev_wdata_intg_o;
  logic [NC-1:0] clr_i;
  logic [NC*CW-1:0] outstanding_o;
  logic [NC*3-1:0]  err_status_o;
  logic          alert_minor_o, alert_major_o;

  int checks = 0;
  int failures = 0;

  ibex_bus_guard #(
    .NumChannels(NC), .MaxOutstanding(MO), .TimeoutCycles(TC), .IntgEnable(1'b1)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .host_req_i(host_req_i), .host_gnt_o(host_gnt_o),
    .host_rvalid_o(host_rvalid_o), .host_err_o(host_err_o),
    .host_wdata_i(host_wdata_i),
    .dev_req_o(dev_req_o), .dev_gnt_i(dev_gnt_i),
    .dev_rvalid_i(dev_rvalid_i), .dev_err_i(dev_err_i),
    .dev_rdata_i(dev_rdata_i), .dev_rdata_intg_i(dev_rdata_intg_i),
    .dev_wdata_intg_o(dev_wdata_intg_o),
    .clr_i(clr_i), .outstanding_o(outstanding_o), .err_status_o(err_status_o),
    .alert_minor_o(alert_minor_o), .alert_major_o(alert_major_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [6:0] enc(input logic [31:0] d);
    logic [6:0] c;
    c[0] = ^(d & 32'h2606BD25);
    c[1] = ^(d & 32'hDEBA8050);
    c[2] = ^(d & 32'h413D89AA);
    c[3] = ^(d & 32'h31234ED1);
    c[4] = ^(d & 32'hC2C1323B);
    c[5] = ^(d & 32'h2DCC624C);
    c[6] = ^(d & 32'h98505586);
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    host_req_i = '0; host_wdata_i = '0; dev_gnt_i = '0; dev_rvalid_i = '0; dev_err_i = '0;
    dev_rdata_i = '0; dev_rdata_intg_i = '0; clr_i = '0;
    tick(); tick();
    check("rst_outstanding", 32'(outstanding_o), 32'h0);
    check("rst_status", 32'(err_status_o), 32'h0);
    check("rst_alert_major", 32'(alert_major_o), 32'h0);
    check("rst_alert_minor", 32'(alert_minor_o), 32'h0);
    rst_ni = 1'b1;
    tick();

    // ---- Throttling on ch1 at MaxOutstanding=2
    host_req_i[1] = 1'b1; dev_gnt_i[1] = 1'b1;
    settle();
    check("thr_req_c0", 32'(dev_req_o[1]), 32'h1);
    check("thr_gnt_c0", 32'(host_gnt_o[1]), 32'h1);
    tick();
    check("thr_cnt1", 32'(outstanding_o[CW +: CW]), 32'h1);
    tick();
    check("thr_cnt2", 32'(outstanding_o[CW +: CW]), 32'h2);
    check("thr_req_full", 32'(dev_req_o[1]), 32'h0);
    check("thr_gnt_full", 32'(host_gnt_o[1]), 32'h0);
    tick();
    check("thr_cnt_hold", 32'(outstanding_o[CW +: CW]), 32'h2);
    dev_rvalid_i[1] = 1'b1;
    settle();
    check("thr_rvalid_fwd", 32'(host_rvalid_o[1]), 32'h1);
    tick();
    check("thr_cnt_drop", 32'(outstanding_o[CW +: CW]), 32'h1);
    check("thr_req_resume", 32'(dev_req_o[1]), 32'h1);
    tick();
    check("thr_cnt_acc_rsp", 32'(outstanding_o[CW +: CW]), 32'h1);
    dev_rvalid_i[1] = 1'b0;
    tick();
    check("thr_cnt_refill", 32'(outstanding_o[CW +: CW]), 32'h2);
    host_req_i[1] = 1'b0; dev_rvalid_i[1] = 1'b1;
    tick(); tick();
    dev_rvalid_i[1] = 1'b0;
    check("thr_cnt_drain", 32'(outstanding_o[CW +: CW]), 32'h0);
    check("thr_status", 32'(err_status_o), 32'h0);

    // ---- Spurious response on ch0
    dev_rvalid_i[0] = 1'b1; dev_err_i[0] = 1'b1;
    settle();
    check("sp_rvalid_supp", 32'(host_rvalid_o[0]), 32'h0);
    check("sp_err_supp", 32'(host_err_o[0]), 32'h0);
    tick();
    dev_rvalid_i[0] = 1'b0; dev_err_i[0] = 1'b0;
    check("sp_status", 32'(err_status_o[2:0]), 32'h1);
    check("sp_cnt", 32'(outstanding_o[CW-1:0]), 32'h0);
    check("sp_major_lag", 32'(alert_major_o), 32'h0);
    tick();
    check("sp_major", 32'(alert_major_o), 32'h1);
    clr_i[0] = 1'b1;
    tick();
    clr_i[0] = 1'b0;
    check("sp_clr_status", 32'(err_status_o[2:0]), 32'h0);
    tick();
    check("sp_clr_major", 32'(alert_major_o), 32'h0);

    // ---- Timeout on ch1 (TimeoutCycles=16)
    host_req_i[1] = 1'b1; dev_gnt_i[1] = 1'b1;
    tick();
    host_req_i[1] = 1'b0;
    check("to_cnt", 32'(outstanding_o[CW +: CW]), 32'h1);
    for (int i = 0; i < 14; i++) tick();
    check("to_not_yet", 32'(err_status_o[5:3]), 32'h0);
    tick();
    check("to_fired", 32'(err_status_o[5:3]), 32'h2);
    host_req_i[1] = 1'b1;
    settle();
    check("to_req_locked", 32'(dev_req_o[1]), 32'h0);
    host_req_i[1] = 1'b0; dev_rvalid_i[1] = 1'b1;
    tick();
    dev_rvalid_i[1] = 1'b0;
    check("to_late_drain", 32'(outstanding_o[CW +: CW]), 32'h0);
    host_req_i[1] = 1'b1;
    settle();
    check("to_still_locked", 32'(dev_req_o[1]), 32'h0);
    host_req_i[1] = 1'b0; clr_i[1] = 1'b1;
    tick();
    clr_i[1] = 1'b0;
    check("to_clr_status", 32'(err_status_o[5:3]), 32'h0);
    host_req_i[1] = 1'b1;
    settle();
    check("to_req_resume", 32'(dev_req_o[1]), 32'h1);
    host_req_i[1] = 1'b0;
    tick(); tick();

    // ---- Integrity generation and checking
    host_wdata_i[63:32] = 32'h0; host_wdata_i[31:0] = 32'h1;
    settle();
    check("wi_zero", 32'(dev_wdata_intg_o[13:7]), 32'h0);
    check("wi_one", 32'(dev_wdata_intg_o[6:0]), 32'h19);
    host_wdata_i[63:32] = 32'hDEADBEEF;
    settle();
    check("wi_deadbeef", 32'(dev_wdata_intg_o[13:7]), 32'(enc(32'hDEADBEEF)));
    host_req_i[1] = 1'b1; dev_gnt_i[1] = 1'b1;
    tick(); tick();
    host_req_i[1] = 1'b0;
    dev_rvalid_i[1] = 1'b1; dev_rdata_i[63:32] = 32'hDEADBEEF;
    dev_rdata_intg_i[13:7] = enc(32'hDEADBEEF);
    settle();
    check("ri_good_err", 32'(host_err_o[1]), 32'h0);
    tick();
    dev_rdata_intg_i[13:7] = enc(32'hDEADBEEF) ^ 7'h04;
    settle();
    check("ri_bad_rvalid", 32'(host_rvalid_o[1]), 32'h1);
    check("ri_bad_err", 32'(host_err_o[1]), 32'h1);
    tick();
    dev_rvalid_i[1] = 1'b0;
    check("ri_status", 32'(err_status_o[5:3]), 32'h4);
    check("ri_no_minor", 32'(alert_minor_o), 32'h0);
    check("ri_cnt", 32'(outstanding_o[CW +: CW]), 32'h0);
    clr_i[1] = 1'b1;
    tick();
    clr_i[1] = 1'b0;
    tick();

    // ---- Device error with valid integrity on ch0
    host_req_i[0] = 1'b1; dev_gnt_i[0] = 1'b1;
    tick();
    host_req_i[0] = 1'b0;
    dev_rvalid_i[0] = 1'b1; dev_err_i[0] = 1'b1;
    dev_rdata_i[31:0] = 32'h1; dev_rdata_intg_i[6:0] = 7'h19;
    settle();
    check("de_rvalid", 32'(host_rvalid_o[0]), 32'h1);
    check("de_err", 32'(host_err_o[0]), 32'h1);
    tick();
    dev_rvalid_i[0] = 1'b0; dev_err_i[0] = 1'b0;
    check("de_minor", 32'(alert_minor_o), 32'h1);
    check("de_status", 32'(err_status_o), 32'h0);
    tick();
    check("de_minor_end", 32'(alert_minor_o), 32'h0);
    check("de_major", 32'(alert_major_o), 32'h0);

    // ---- Reset mid-transaction
    host_req_i[1] = 1'b1; dev_gnt_i = 2'b11;
    tick(); tick();
    host_req_i[1] = 1'b0;
    tick(); tick();
    check("mr_cnt_pre", 32'(outstanding_o[CW +: CW]), 32'h2);
    rst_ni = 1'b0;
    settle();
    check("mr_cnt", 32'(outstanding_o), 32'h0);
    check("mr_status", 32'(err_status_o), 32'h0);
    check("mr_dev_req", 32'(dev_req_o), 32'h0);
    check("mr_major", 32'(alert_major_o), 32'h0);
    tick();
    rst_ni = 1'b1;
    tick();
    dev_rvalid_i[1] = 1'b1;
    settle();
    check("mr_stale_supp", 32'(host_rvalid_o[1]), 32'h0);
    tick();
    dev_rvalid_i[1] = 1'b0;
    check("mr_stale_spur", 32'(err_status_o[5:3]), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
